// File: rtl/inst_fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } if_state_t;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Redirect targets are word addresses; low bits are dropped on load.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, runs the req/ack handshake to instruction
// memory and presents one instruction at a time to the IF/ID register.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [31:0] new_pc,
    input  logic        branch_flag,
    input  logic [31:0] branch_target,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst,
    output logic        stallreq
);

    if_state_t   r_state, w_state_nxt;
    logic [31:0] r_pc, w_pc_nxt;
    logic        r_mem_req, w_mem_req_nxt;
    logic [31:0] r_mem_addr, w_mem_addr_nxt;
    logic [31:0] r_if_pc, w_if_pc_nxt;
    logic [31:0] r_if_inst, w_if_inst_nxt;
    logic [31:0] w_flush_pc, w_branch_pc, w_seq_pc;
    logic        w_unused;

    assign w_flush_pc  = word_align(new_pc);
    assign w_branch_pc = word_align(branch_target);
    assign w_seq_pc    = r_pc + 32'(PC_STEP);
    assign w_unused    = ^stall[5:1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_mem_req_nxt  = r_mem_req;
        w_mem_addr_nxt = r_mem_addr;
        w_if_pc_nxt    = r_if_pc;
        w_if_inst_nxt  = r_if_inst;
        case (r_state)
            S_IDLE: begin
                w_state_nxt    = S_REQ;
                w_mem_req_nxt  = 1'b1;
                w_mem_addr_nxt = r_pc;
            end
            S_REQ: begin
                if (flush || (branch_flag && !stall[0])) begin
                    w_pc_nxt = flush ? w_flush_pc : w_branch_pc;
                    // Without an ack the old address must stay on the bus until it drains.
                    if (mem_ack) w_mem_addr_nxt = w_pc_nxt;
                    else         w_state_nxt    = S_DRAIN;
                end else if (mem_ack) begin
                    w_if_pc_nxt   = r_pc;
                    w_if_inst_nxt = mem_rdata;
                    w_mem_req_nxt = 1'b0;
                    w_state_nxt   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (flush) begin
                    w_if_pc_nxt    = ZERO_WORD;
                    w_if_inst_nxt  = ZERO_WORD;
                    w_pc_nxt       = w_flush_pc;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = w_flush_pc;
                    w_state_nxt    = S_REQ;
                end else if (!stall[0]) begin
                    w_pc_nxt       = branch_flag ? w_branch_pc : w_seq_pc;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = w_pc_nxt;
                    w_state_nxt    = S_REQ;
                end
            end
            S_DRAIN: begin
                if (flush) w_pc_nxt = w_flush_pc;
                if (mem_ack) begin
                    w_mem_addr_nxt = w_pc_nxt;
                    w_state_nxt    = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_mem_addr <= ZERO_WORD;
            r_if_pc    <= ZERO_WORD;
            r_if_inst  <= ZERO_WORD;
        end else begin
            r_pc       <= w_pc_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_if_pc    <= w_if_pc_nxt;
            r_if_inst  <= w_if_inst_nxt;
        end
    end

    always_comb begin
        stallreq = (r_state != S_HOLD);
        mem_req  = r_mem_req;
        mem_addr = r_mem_addr;
        if_pc    = r_if_pc;
        if_inst  = r_if_inst;
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch; a second instance starts near the top of the
// address space to exercise PC wrap.
module tb_inst_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  stall = 6'd0;
    logic        flush = 1'b0;
    logic [31:0] new_pc = 32'd0;
    logic        branch_flag = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        ack_ok = 1'b1;

    logic        mem_req, mem_ack, stallreq;
    logic [31:0] mem_addr, mem_rdata, if_pc, if_inst;

    logic        w2_req, w2_ack, w2_stallreq;
    logic [31:0] w2_addr, w2_rdata, w2_if_pc, w2_if_inst;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign mem_ack   = mem_req & ack_ok;
    assign mem_rdata = mem_addr | 32'hA500_0000;
    assign w2_ack    = w2_req;
    assign w2_rdata  = w2_addr | 32'hA500_0000;

    inst_fetch u_dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .new_pc(new_pc),
        .branch_flag(branch_flag), .branch_target(branch_target),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .if_pc(if_pc), .if_inst(if_inst), .stallreq(stallreq)
    );

    inst_fetch #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst), .stall(6'd0), .flush(1'b0), .new_pc(32'd0),
        .branch_flag(1'b0), .branch_target(32'd0),
        .mem_req(w2_req), .mem_addr(w2_addr), .mem_ack(w2_ack),
        .mem_rdata(w2_rdata), .if_pc(w2_if_pc), .if_inst(w2_if_inst), .stallreq(w2_stallreq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_req(input string tag, input logic [31:0] addr);
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd1);
        chk({tag, "_addr"}, mem_addr, addr);
        chk({tag, "_stallreq"}, {31'd0, stallreq}, 32'd1);
    endtask

    task automatic chk_hold(input string tag, input logic [31:0] pc);
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_if_pc"}, if_pc, pc);
        chk({tag, "_if_inst"}, if_inst, pc | 32'hA500_0000);
        chk({tag, "_stallreq"}, {31'd0, stallreq}, 32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        chk("rst_if_inst", if_inst, 32'd0);
        chk("rst_stallreq", {31'd0, stallreq}, 32'd1);
        rst = 1'b1;

        // Sequential fetch with zero-wait memory
        tick(); chk_req("seq0", 32'h0);
        chk("wrap0", w2_addr, 32'hFFFF_FFF8);
        tick(); chk_hold("seq0h", 32'h0);
        tick(); chk_req("seq4", 32'h4);
        chk("wrap1", w2_addr, 32'hFFFF_FFFC);
        tick(); chk_hold("seq4h", 32'h4);
        tick(); chk_req("seq8", 32'h8);
        chk("wrap2", w2_addr, 32'h0);
        stall = 6'd1;
        tick(); chk_hold("seq8h", 32'h8);
        chk("wrap2h_if_pc", w2_if_pc, 32'h0);

        // IF stall holds the presented instruction
        for (int i = 0; i < 3; i++) begin
            tick(); chk_hold("stall", 32'h8);
        end
        stall = 6'd0;
        tick(); chk_req("after_stall", 32'hC);
        tick(); chk_hold("seqCh", 32'hC);

        // Taken branch from ID, misaligned target
        branch_flag = 1'b1;
        branch_target = 32'h0000_1003;
        tick(); chk_req("branch", 32'h1000);
        branch_flag = 1'b0;
        tick(); chk_hold("branch_h", 32'h1000);

        // Flush during an outstanding request with delayed ack
        ack_ok = 1'b0;
        tick(); chk_req("pre_flush", 32'h1004);
        flush = 1'b1;
        new_pc = 32'h0000_0200;
        tick(); chk_req("drain0", 32'h1004);
        flush = 1'b0;
        tick(); chk_req("drain1", 32'h1004);
        tick(); chk_req("drain2", 32'h1004);
        ack_ok = 1'b1;
        tick(); chk_req("redirect", 32'h200);
        chk("discard_if_pc", if_pc, 32'h1000);
        tick(); chk_hold("flush_h", 32'h200);

        // Reset asserted mid-request
        tick(); chk_req("pre_rst", 32'h204);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req", {31'd0, mem_req}, 32'd0);
        chk("arst_if_pc", if_pc, 32'd0);
        chk("arst_if_inst", if_inst, 32'd0);
        chk("arst_stallreq", {31'd0, stallreq}, 32'd1);
        tick();
        rst = 1'b1;
        tick(); chk_req("restart", 32'h0);
        tick(); chk_hold("restart_h", 32'h0);

        // Flush beats stall and branch while holding
        flush = 1'b1;
        new_pc = 32'h0000_0303;
        stall = 6'd1;
        branch_flag = 1'b1;
        branch_target = 32'h0000_0500;
        tick(); chk_req("hold_flush", 32'h300);
        chk("hold_flush_if_pc", if_pc, 32'd0);
        chk("hold_flush_if_inst", if_inst, 32'd0);
        flush = 1'b0;
        branch_flag = 1'b0;
        stall = 6'd0;
        tick(); chk_hold("hold_flush_h", 32'h300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch.md
Name: inst_fetch

Overview:
- Instruction-fetch front end: owns the PC and issues word requests to instruction memory over a req/ack handshake.
- Produces if_pc/if_inst for the IF/ID stage register.
- Raises stallreq to the pipeline controller while no fetched instruction is available.
- Honours stall[0], branch redirects from ID and flush redirects from the controller.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0).
- PC_STEP, 4, byte increment between sequential fetches.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- stall  in  6  pipeline stall vector; only bit 0 (IF stall) is used here
- flush  in  1  redirect to new_pc, highest priority
- new_pc  in  32  flush target
- branch_flag  in  1  ID-stage taken branch
- branch_target  in  32  branch target
- mem_req  out  1  instruction memory request
- mem_addr  out  32  request address, held stable while mem_req=1
- mem_ack  in  1  one-cycle acknowledge; mem_rdata valid in the same cycle
- mem_rdata  in  32  fetched word
- if_pc  out  32  PC of presented instruction
- if_inst  out  32  presented instruction; `ZeroWord = NOP
- stallreq  out  1  IF stage has no valid instruction; request a pipeline stall

Behaviour:
- Reset (rst=0, asynchronous):
  - state=S_IDLE, pc=RESET_PC.
  - mem_req=0, mem_addr=0, if_pc=0, if_inst=0, stallreq=1.
- Registers: mem_req, mem_addr, if_pc and if_inst are registered. stallreq is decoded from the state register: 0 only in S_HOLD.
- Redirect targets: bits [1:0] are forced to 00 when loaded into pc. PC increments wrap modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
- S_IDLE: the next edge goes to S_REQ with mem_req=1, mem_addr=pc.
- S_REQ: waiting for ack; evaluate in this priority order.
  - flush, no ack: pc=new_pc → S_DRAIN. mem_req stays 1 and mem_addr stays at the old address.
  - flush with ack: discard data; pc=new_pc, mem_addr=new_pc, mem_req stays 1; remain in S_REQ.
  - branch_flag with stall[0]=0: same as flush, using branch_target.
  - ack otherwise: if_pc=pc, if_inst=mem_rdata, mem_req=0 → S_HOLD.
  - no ack: hold all outputs.
- S_HOLD: instruction presented, stallreq=0.
  - flush: if_pc=0, if_inst=0, pc=new_pc, mem_req=1, mem_addr=new_pc → S_REQ.
  - stall[0]=1: hold everything. The instruction is not consumed, so it is never lost or duplicated.
  - stall[0]=0: the IF/ID register consumes if_* at this edge. Set pc = branch_flag ? branch_target : pc+PC_STEP. Set mem_req=1, mem_addr = next pc → S_REQ.
- S_DRAIN: mem_req=1 with the stale address, stallreq=1.
  - ack: discard data; mem_addr=pc, mem_req stays 1 → S_REQ.
  - flush without ack: pc=new_pc, remain in S_DRAIN.
  - flush with ack: pc=new_pc, mem_addr=new_pc → S_REQ.
  - branch_flag is ignored in S_DRAIN.
- Handshake rules:
  - mem_addr never changes while mem_req=1 and no ack has been seen.
  - At most one request is outstanding.
  - An ack while mem_req=0 is ignored.
- Latency:
  - Zero-wait-state memory (ack in the first S_REQ cycle): one instruction per 2 cycles (S_REQ, S_HOLD).
  - First instruction visible 2 cycles after reset release plus memory latency.
- Flush, branch_flag and a stall on the same edge: flush wins. Branch is applied only when stall[0]=0.
- Reset asserted mid-request: the request is abandoned immediately. The memory side must tolerate mem_req dropping without an ack.

Decomposition:
- defines.v holds `ZeroWord, `InstAddrBus, `InstBus, the state encodings (`IF_IDLE, `IF_REQ, `IF_HOLD, `IF_DRAIN, 2-bit) and `IfInstStep.
- No sub-module. Next-PC mux and adder stay inline.

Test Plan:
- Reset release, memory acks in the cycle after each req with word = address | 0xA5000000:
  - mem_addr sequence 0,4,8,…
  - if_pc/if_inst show 0/0xA5000000, 4/0xA5000004, …
  - stallreq toggles 1,0 each instruction.
- stall[0] held 3 cycles while in S_HOLD with if_pc=8: outputs frozen at 8; no mem_req; after release the next mem_addr=0xC.
- branch_flag=1, branch_target=0x1003 in S_HOLD with stall[0]=0: next mem_addr=0x1000, and the following if_pc=0x1000.
- flush with new_pc=0x200 in S_REQ, ack delayed 3 cycles:
  - mem_addr stays at the old address until ack; the acked data is not presented.
  - next request addr=0x200; stallreq=1 throughout.
- PC wrap: RESET_PC=0xFFFFFFF8, zero-wait memory: addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0.
- rst pulled low while mem_req=1: mem_req, if_pc, if_inst go 0 and stallreq goes 1 asynchronously; after release, fetch restarts at RESET_PC.
